// File: rtl/peg_pkt_xfr_arb.sv
// Round-robin packet arbiter: NUM_SRC packet sources share one sink.
// A grant is held from the SOP transfer through the EOP transfer, and at least one IDLE cycle separates packets.
module peg_pkt_xfr_arb #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned NUM_SRC = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC-1:0]        src_sop,
   input  logic [NUM_SRC-1:0]        src_eop,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [NUM_SRC-1:0]        src_error,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic                      snk_sop,
   output logic                      snk_eop,
   output logic                      snk_valid,
   output logic                      snk_error,
   output logic [DATA_W-1:0]         snk_data,
   input  logic                      snk_ready,
   output logic [NUM_SRC-1:0]        gnt
);

   localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q;
   logic [IDX_W-1:0]   sel_q;
   logic [IDX_W-1:0]   last_q;
   logic [NUM_SRC-1:0] gnt_q;

   logic [NUM_SRC-1:0] cand;
   logic [IDX_W-1:0]   pick_d;
   logic               found_d;
   int unsigned        idx;

   assign cand = src_valid & src_sop;
   assign gnt  = gnt_q;

   // Scan upward from last_q+1 with wrap; the first candidate seen wins.
   always_comb begin
      found_d = 1'b0;
      pick_d  = '0;
      idx     = 0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         idx = 32'(last_q) + 32'd1 + i;
         if (idx >= NUM_SRC) begin
            idx = idx - NUM_SRC;
         end
         if (!found_d && cand[idx[IDX_W-1:0]]) begin
            found_d = 1'b1;
            pick_d  = idx[IDX_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         last_q  <= IDX_W'(NUM_SRC - 1);
      end else begin
         case (state_q)
            IDLE: begin
               if (found_d) begin
                  state_q <= BUSY;
                  sel_q   <= pick_d;
                  gnt_q   <= ONE_HOT0 << pick_d;
               end
            end
            BUSY: begin
               if (src_valid[sel_q] && snk_ready && src_eop[sel_q]) begin
                  state_q <= IDLE;
                  last_q  <= sel_q;
                  gnt_q   <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // While BUSY the sink side is a straight combinational mux of the granted source.
   always_comb begin
      src_ready = '0;
      snk_valid = 1'b0;
      snk_sop   = 1'b0;
      snk_eop   = 1'b0;
      snk_error = 1'b0;
      snk_data  = '0;
      if (state_q == BUSY) begin
         snk_valid        = src_valid[sel_q];
         snk_sop          = src_sop[sel_q];
         snk_eop          = src_eop[sel_q];
         snk_error        = src_error[sel_q];
         snk_data         = src_data[32'(sel_q)*DATA_W +: DATA_W];
         src_ready[sel_q] = snk_ready;
      end
   end

endmodule

// File: tb/tb_peg_pkt_xfr_arb.sv
// Self-checking bench for peg_pkt_xfr_arb: directed scenarios plus randomized traffic against a round-robin reference model.
module tb_peg_pkt_xfr_arb;

   localparam int N  = 4;
   localparam int DW = 16;

   logic            clk, rst;
   logic [N-1:0]    src_sop, src_eop, src_valid, src_error, src_ready, gnt;
   logic [N*DW-1:0] src_data;
   logic            snk_sop, snk_eop, snk_valid, snk_error, snk_ready;
   logic [DW-1:0]   snk_data;

   peg_pkt_xfr_arb #(.DATA_W(DW), .NUM_SRC(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .src_sop   (src_sop),
      .src_eop   (src_eop),
      .src_valid (src_valid),
      .src_data  (src_data),
      .src_error (src_error),
      .src_ready (src_ready),
      .snk_sop   (snk_sop),
      .snk_eop   (snk_eop),
      .snk_valid (snk_valid),
      .snk_error (snk_error),
      .snk_data  (snk_data),
      .snk_ready (snk_ready),
      .gnt       (gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests, n_fail;

   // Source traffic: plen = words in the current packet (0 = none), ppos = next word index.
   int plen [N];
   int ppos [N];
   bit junk [N];
   bit refill, stall_en, rdy_rand, tog_en, tog_val;
   int refill_len;

   // Reference model: busy flag, granted source, last winner.
   bit m_busy;
   int m_g, m_last;
   int xfers, pos_cnt;
   int order[$];
   logic [N-1:0] gnt_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         plen[i] = 0;
         ppos[i] = 0;
         junk[i] = 0;
      end
      refill = 0; stall_en = 0; rdy_rand = 0; tog_en = 0;
      m_busy = 0; m_g = 0; m_last = N - 1; pos_cnt = 0;
   endtask

   function automatic bit pending();
      bit p;
      p = m_busy;
      for (int i = 0; i < N; i++) if (plen[i] > 0) p = 1;
      return p;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         logic [DW-1:0] w;
         w = DW'($urandom);
         src_valid[i] = 0; src_sop[i] = 0; src_eop[i] = 0;
         src_error[i] = 1'($urandom);
         if (plen[i] > 0 && !(stall_en && $urandom_range(0, 3) == 0)) begin
            src_valid[i] = 1;
            src_sop[i]   = (ppos[i] == 0);
            src_eop[i]   = (ppos[i] == plen[i] - 1);
            w[15:8]      = {4'(i), 4'(ppos[i])};
         end else if (plen[i] == 0 && junk[i]) begin
            src_valid[i] = 1;
            src_eop[i]   = 1'($urandom);
         end
         src_data[i*DW +: DW] = w;
      end
      if (rdy_rand) snk_ready = 1'($urandom);
      else if (tog_en) begin
         snk_ready = tog_val;
         tog_val   = !tog_val;
      end else snk_ready = 1;
   endtask

   task automatic check();
      logic [N-1:0] eg, er;
      eg = '0; er = '0;
      if (m_busy) begin
         eg[m_g] = 1'b1;
         er[m_g] = snk_ready;
      end
      chk("gnt",       gnt,       eg);
      chk("src_ready", src_ready, er);
      chk("snk_valid", snk_valid, m_busy ? src_valid[m_g] : 1'b0);
      chk("snk_sop",   snk_sop,   m_busy ? src_sop[m_g]   : 1'b0);
      chk("snk_eop",   snk_eop,   m_busy ? src_eop[m_g]   : 1'b0);
      chk("snk_error", snk_error, m_busy ? src_error[m_g] : 1'b0);
      chk("snk_data",  snk_data,  m_busy ? src_data[m_g*DW +: DW] : 16'h0);
      gnt_log.push_back(gnt);
      if (snk_valid && snk_ready) begin
         if (snk_sop) pos_cnt = 0;
         chk("word_pos", snk_data[11:8],  4'(pos_cnt));
         chk("word_src", snk_data[15:12], 4'(m_g));
         pos_cnt++;
         xfers++;
      end
   endtask

   task automatic update();
      if (!m_busy) begin
         bit found;
         found = 0;
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (!found && src_valid[j] && src_sop[j]) begin
               found = 1; m_busy = 1; m_g = j;
               order.push_back(j);
            end
         end
      end else if (src_valid[m_g] && snk_ready) begin
         if (src_eop[m_g]) begin
            m_busy = 0; m_last = m_g; ppos[m_g] = 0;
            plen[m_g] = refill ? refill_len : 0;
         end else ppos[m_g]++;
      end
   endtask

   task automatic step();
      drive();
      @(negedge clk);
      check();
      @(posedge clk);
      update();
      #1;
   endtask

   task automatic do_reset();
      rst = 0;
      clear_model();
      src_valid = '0; src_sop = '0; src_eop = '0; src_error = '0; src_data = '0;
      snk_ready = 1;
      #1;
      chk("rst_gnt",       gnt,       0);
      chk("rst_src_ready", src_ready, 0);
      chk("rst_snk_valid", snk_valid, 0);
      chk("rst_snk_data",  snk_data,  0);
      @(posedge clk);
      #1;
      rst = 1;
      gnt_log.delete(); order.delete(); xfers = 0;
   endtask

   task automatic drain(input string tag, input int budget);
      for (int t = 0; t < budget && pending(); t++) step();
      chk(tag, pending(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_order [5];
      n_tests = 0; n_fail = 0; rst = 0; tog_val = 0; refill_len = 0;
      exp_order = '{0, 1, 2, 3, 0};

      // 3-word packet from source 0
      do_reset();
      plen[0] = 3;
      repeat (5) step();
      chk("s1_gnt_next_cycle", gnt_log[1], 4'b0001);
      chk("s1_xfers",          xfers,      3);
      chk("s1_idle_after_eop", gnt_log[4], 4'b0000);

      // all sources request continuously with 2-word packets
      do_reset();
      for (int i = 0; i < N; i++) plen[i] = 2;
      refill = 1; refill_len = 2;
      repeat (16) step();
      refill = 0;
      for (int k = 0; k < 5; k++)
         chk("s2_order", (order.size() > k) ? order[k] : -1, exp_order[k]);
      drain("s2_drained", 40);

      // snk_ready toggling during a 4-word packet from source 2
      do_reset();
      tog_en = 1; tog_val = 0;
      plen[2] = 4;
      repeat (9) step();
      tog_en = 0;
      chk("s3_gnt",   gnt_log[1], 4'b0100);
      chk("s3_xfers", xfers,      4);
      chk("s3_idle",  gnt_log[8], 4'b0000);

      // single-word packet from source 1, then source 3
      do_reset();
      plen[1] = 1;
      step();
      plen[3] = 1;
      repeat (3) step();
      chk("s4_gnt_c0", gnt_log[0], 4'b0000);
      chk("s4_gnt_c1", gnt_log[1], 4'b0010);
      chk("s4_gnt_c2", gnt_log[2], 4'b0000);
      chk("s4_gnt_c3", gnt_log[3], 4'b1000);
      drain("s4_drained", 10);

      // reset pulsed in the second word of a source 0 packet
      do_reset();
      plen[0] = 3;
      repeat (2) step();
      drive();
      @(negedge clk);
      check();
      rst = 0;
      #1;
      chk("s5_rst_gnt",       gnt,       0);
      chk("s5_rst_snk_valid", snk_valid, 0);
      chk("s5_rst_snk_eop",   snk_eop,   0);
      chk("s5_rst_src_ready", src_ready, 0);
      chk("s5_rst_snk_data",  snk_data,  0);
      clear_model();
      @(posedge clk);
      #1;
      rst = 1;
      gnt_log.delete();
      plen[0] = 2; plen[1] = 2;
      repeat (2) step();
      chk("s5_gnt_after_rst", gnt_log[1], 4'b0001);
      drain("s5_drained", 20);

      // source 1 valid without sop while idle
      do_reset();
      junk[1] = 1;
      repeat (8) step();
      junk[1] = 0;
      chk("s6_no_grant", order.size(), 0);
      chk("s6_no_xfer",  xfers,        0);

      // randomized traffic: stalls, random snk_ready, junk words, error bits
      do_reset();
      stall_en = 1; rdy_rand = 1;
      repeat (600) begin
         for (int i = 0; i < N; i++) begin
            if (plen[i] == 0 && $urandom_range(0, 3) == 0) plen[i] = $urandom_range(1, 4);
            junk[i] = ($urandom_range(0, 7) == 0);
         end
         step();
      end
      for (int i = 0; i < N; i++) junk[i] = 0;
      stall_en = 0; rdy_rand = 0;
      drain("rand_drained", 100);
      chk("rand_grants_seen", order.size() > 20, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/peg_pkt_xfr_arb.md
PEG_PKT_XFR_ARB -- requirements
Module: peg_pkt_xfr_arb

Interface
REQ-001 Parameter DATA_W, default 16: packet data width in bits.
REQ-002 Parameter NUM_SRC, default 4, legal 2..8: number of requesting packet sources.
REQ-003 Reset and clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 src_sop  input  NUM_SRC  per-source start-of-packet.
REQ-007 src_eop  input  NUM_SRC  per-source end-of-packet.
REQ-008 src_valid  input  NUM_SRC  per-source data valid.
REQ-009 src_data  input  NUM_SRC*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W].
REQ-010 src_error  input  NUM_SRC  per-source packet error flag.
REQ-011 src_ready  output  NUM_SRC  per-source ready.
REQ-012 snk_sop, snk_eop, snk_valid, snk_error  output  1 each  arbitrated master-side packet signals.
REQ-013 snk_data  output  DATA_W  arbitrated data.
REQ-014 snk_ready  input  1  downstream ready.
REQ-015 gnt  output  NUM_SRC  one-hot current grant; all-zero when idle.

Function
REQ-016 A transfer on any side SHALL occur only in a cycle where valid and ready are both 1.
REQ-017 The block SHALL implement a two-state FSM: IDLE and BUSY.
REQ-018 In IDLE, a source SHALL be a candidate only when its src_valid and src_sop are both 1.
REQ-019 In IDLE with one or more candidates, the block SHALL register a grant to the first candidate searching upward (with wrap-around) from last_gnt+1, and SHALL move to BUSY on that edge.
REQ-020 Arbitration latency SHALL be one cycle: the granted source's first word appears on snk_* in the cycle after the candidate is sampled.
REQ-021 In IDLE, snk_valid, snk_sop, snk_eop and snk_error SHALL be 0, and all src_ready bits SHALL be 0.
REQ-022 In BUSY, the snk_* outputs SHALL combinationally mirror the granted source's signals.
REQ-023 In BUSY, src_ready[g] SHALL equal snk_ready for the granted source g; every other src_ready bit SHALL be 0.
REQ-024 The grant SHALL be held from the SOP transfer through the EOP transfer, with no interleaving of other sources.
REQ-025 On a transfer with src_eop=1, the block SHALL:
  - return to IDLE on that edge;
  - set last_gnt to g;
  - clear gnt.
REQ-026 After an EOP transfer, at least one IDLE cycle SHALL precede the next grant.
REQ-027 A single-word packet (sop and eop on the same transfer) SHALL complete in one BUSY cycle.
REQ-028 If the granted source drops src_valid mid-packet, BUSY and the grant SHALL be held indefinitely; no timeout applies.
REQ-029 Valid words without sop from a non-granted source SHALL be stalled (ready=0) and never forwarded.
REQ-030 snk_error SHALL pass through unmodified; it SHALL NOT affect arbitration or packet termination.
REQ-031 Simultaneous candidates SHALL be resolved by round-robin order only.
REQ-032 Under continuous requests from all sources, each source SHALL win once per NUM_SRC packets.

Reset
REQ-033 When rst=0, the block SHALL asynchronously force:
  - state=IDLE;
  - gnt=0;
  - last_gnt=NUM_SRC-1, so that source 0 has first priority;
  - snk_valid/sop/eop/error=0, snk_data=0, src_ready=0.
REQ-034 Reset asserted mid-packet SHALL abandon the packet; no EOP is generated on snk_*.
REQ-035 After rst deasserts, arbitration SHALL restart per REQ-019.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
  - Reset, then src_valid=src_sop=0001 with a 3-word packet and snk_ready=1 -> gnt=0001 one cycle later; three snk transfers; IDLE after the EOP edge.
  - All four sources request continuously with 2-word packets -> grant order 0,1,2,3,0; each packet contiguous.
  - snk_ready toggling 1,0,1,0 during a 4-word packet from source 2 -> src_ready[2] tracks snk_ready; data order preserved; other src_ready bits 0.
  - Single-word packet from source 1 (sop=eop=1) followed by a source 3 request -> one BUSY cycle, one IDLE cycle, then gnt=1000.
  - rst pulsed low in the second word of a source 0 packet -> outputs 0 immediately; after release with sources 0 and 1 requesting, gnt=0001.
  - Source 1 valid without sop while idle -> never granted, src_ready[1]=0, snk_valid=0.
